serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 13 +
 rtl/serial_tx_if.sv | 13 +
 rtl/serial_baud_gen.sv | 25 ++
 rtl/serial_tx.sv | 78 +++++++
 tb/tb_serial_tx.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and FSM state type for the serial transmitter.
// Optional feature macro: SERIAL_TX_PARITY_EN adds the PARITY state.
package serial_pkg;
   localparam int   DATA_W     = 8;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: byte handshake and serial line bundle.
// Signals: tx_data/tx_valid (to transmitter), tx_ready, out, busy, done (from transmitter).
interface serial_tx_if;
   import serial_pkg::*;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              out;
   logic              busy;
   logic              done;
   modport master (output tx_data, tx_valid, input tx_ready, out, busy, done);
   modport slave  (input tx_data, tx_valid, output tx_ready, out, busy, done);
endinterface

// File: rtl/serial_baud_gen.sv
// serial_baud_gen: bit-time counter producing a one-cycle tick in the last cycle of each bit.
// Ports: clk, rst (async high), i_run (frame active), o_tick (last cycle of bit),
//        o_tick_next (o_tick will be high next cycle if the frame keeps running).
module serial_baud_gen #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_run,
   output logic o_tick,
   output logic o_tick_next
);
   localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_next;
   // Idle keeps the counter preloaded so the first START bit gets a full bit-time.
   always_comb begin
      o_tick      = i_run && (r_cnt == 16'd0);
      w_cnt_next  = (!i_run || o_tick) ? RELOAD : r_cnt - 16'd1;
      o_tick_next = (w_cnt_next == 16'd0);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) r_cnt <= '0;
      else     r_cnt <= w_cnt_next;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: 8N1 serial transmitter with one-entry holding register (optional parity via SERIAL_TX_PARITY_EN).
// Ports: clk, rst (async high), bus (serial_tx_if.slave: tx_data, tx_valid, tx_ready, out, busy, done).
module serial_tx
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input logic        clk,
   input logic        rst,
   serial_tx_if.slave bus
);
   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_hold, r_data, w_data_next;
   logic [2:0]        r_idx, w_idx_next;
   logic              r_hold_full, w_hold_full_next;
   logic              r_out, r_busy, r_done;
   logic              w_tick, w_tick_next, w_run, w_accept, w_start, w_level;
   assign w_run = (r_state != IDLE);
   serial_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk         (clk),
      .rst         (rst),
      .i_run       (w_run),
      .o_tick      (w_tick),
      .o_tick_next (w_tick_next)
   );
   always_comb begin
      w_accept = bus.tx_valid && !r_hold_full;
      w_next   = r_state;
      case (r_state)
         IDLE:   if (r_hold_full) w_next = START;
         START:  if (w_tick) w_next = DATA;
`ifdef SERIAL_TX_PARITY_EN
         DATA:   if (w_tick && &r_idx) w_next = PARITY;
         PARITY: if (w_tick) w_next = STOP;
`else
         DATA:   if (w_tick && &r_idx) w_next = STOP;
`endif
         // A byte accepted in the final stop cycle still chains without a gap.
         STOP:   if (w_tick) w_next = (r_hold_full || w_accept) ? START : IDLE;
         default: w_next = IDLE;
      endcase
      w_start          = (w_next == START) && (r_state != START);
      w_data_next      = w_start ? (r_hold_full ? r_hold : bus.tx_data) : r_data;
      w_hold_full_next = w_start ? 1'b0 : (r_hold_full || w_accept);
      w_idx_next       = (r_state == DATA && w_tick) ? r_idx + 3'd1 : r_idx;
      // The line level is registered from the next state so out has no input path.
      w_level = (w_next == START) ? START_BIT :
                (w_next == DATA)  ? w_data_next[w_idx_next] :
                (w_next == IDLE)  ? IDLE_LEVEL : STOP_BIT;
`ifdef SERIAL_TX_PARITY_EN
      if (w_next == PARITY) w_level = ~^w_data_next;
`endif
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state     <= IDLE;
         r_hold      <= '0;
         r_data      <= '0;
         r_idx       <= '0;
         r_hold_full <= 1'b0;
         r_out       <= IDLE_LEVEL;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_hold      <= w_accept ? bus.tx_data : r_hold;
         r_data      <= w_data_next;
         r_idx       <= w_idx_next;
         r_hold_full <= w_hold_full_next;
         r_out       <= w_level;
         r_busy      <= (w_next != IDLE) || w_hold_full_next;
         r_done      <= (w_next == STOP) && w_tick_next;
      end
   assign bus.tx_ready = !r_hold_full;
   assign bus.out      = r_out;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed and loopback bench for serial_tx (CLKS_PER_BIT 1 and 4 instances).
module tb_serial_tx;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   serial_tx_if ifa ();
   serial_tx_if ifb ();
   serial_tx #(.CLKS_PER_BIT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   serial_tx #(.CLKS_PER_BIT(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [10:0] frame(input logic [7:0] d);
`ifdef SERIAL_TX_PARITY_EN
      return {1'b1, ~^d, d, 1'b0};
`else
      return {2'b01, d, 1'b0};
`endif
   endfunction
   // Loopback receiver model on the CLKS_PER_BIT=1 line, sampled mid-cycle.
   logic [7:0] exp_q[$];
   logic [7:0] rx_sh = '0;
   logic [7:0] exp_b;
   int rx_pos = 0, rx_cnt = 0, acc_cnt = 0, done_cnt = 0;
   always @(posedge clk)
      if (!rst && ifa.tx_valid && ifa.tx_ready) begin
         exp_q.push_back(ifa.tx_data);
         acc_cnt++;
      end
   always @(negedge clk) begin
      if (rst) begin
         rx_pos = 0; rx_cnt = 0; acc_cnt = 0; done_cnt = 0;
         exp_q.delete();
      end else begin
         if (ifa.done) done_cnt++;
         if (rx_pos == 0) begin
            if (ifa.out == 1'b0) rx_pos = 1;
         end else if (rx_pos <= 8) begin
            rx_sh[rx_pos-1] = ifa.out;
            rx_pos++;
         end else if (rx_pos < NB - 1) begin
            chk("rx_parity", ifa.out, ~^rx_sh);
            rx_pos++;
         end else begin
            chk("rx_stop", ifa.out, 1);
            chk("rx_done", ifa.done, 1);
            exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("rx_byte", rx_sh, exp_b);
            rx_cnt++;
            rx_pos = 0;
         end
      end
   end
   task automatic send_a(input logic [7:0] d);
      logic [10:0] f;
      f = frame(d);
      ifa.tx_valid = 1'b1;
      ifa.tx_data  = d;
      step();
      ifa.tx_valid = 1'b0;
      chk("accept_ready", ifa.tx_ready, 0);
      chk("accept_out_idle", ifa.out, 1);
      for (int i = 0; i < NB; i++) begin
         step();
         chk("a_out", ifa.out, f[i]);
         chk("a_done", ifa.done, i == NB - 1);
         chk("a_busy", ifa.busy, 1);
      end
      step();
      chk("a_end_out", ifa.out, 1);
      chk("a_end_busy", ifa.busy, 0);
      chk("a_end_done", ifa.done, 0);
   endtask
   initial begin
      logic [10:0] f, g;
      logic        rdy;
      int          sent, cyc;
      ifa.tx_valid = 1'b0; ifa.tx_data = '0;
      ifb.tx_valid = 1'b0; ifb.tx_data = '0;
      step();
      chk("rst_out", ifa.out, 1);
      chk("rst_ready", ifa.tx_ready, 1);
      chk("rst_busy", ifa.busy, 0);
      chk("rst_done", ifa.done, 0);
      rst = 1'b0;
      // 0xA5 at one cycle per bit: 0,1,0,1,0,0,1,0,1,(parity),1
      send_a(8'hA5);
      // 0x00 then 0xFF offered during DATA: contiguous frames
      f = frame(8'h00);
      g = frame(8'hFF);
      ifa.tx_valid = 1'b1; ifa.tx_data = 8'h00;
      step();
      ifa.tx_valid = 1'b0;
      for (int i = 0; i < 2 * NB; i++) begin
         step();
         chk("b2b_out", ifa.out, (i < NB) ? f[i] : g[i-NB]);
         chk("b2b_ready", ifa.tx_ready, !(i >= 3 && i < NB));
         chk("b2b_done", ifa.done, (i == NB - 1) || (i == 2 * NB - 1));
         if (i == 2) begin ifa.tx_valid = 1'b1; ifa.tx_data = 8'hFF; end
         if (i == 3) ifa.tx_valid = 1'b0;
      end
      step();
      chk("b2b_end_busy", ifa.busy, 0);
      // 0x3C at four cycles per bit
      f = frame(8'h3C);
      ifb.tx_valid = 1'b1; ifb.tx_data = 8'h3C;
      step();
      ifb.tx_valid = 1'b0;
      for (int i = 0; i < 4 * NB; i++) begin
         step();
         chk("c4_out", ifb.out, f[i/4]);
         chk("c4_done", ifb.done, i == 4 * NB - 1);
         chk("c4_busy", ifb.busy, 1);
      end
      step();
      chk("c4_busy_fall", ifb.busy, 0);
      chk("c4_done_fall", ifb.done, 0);
      // Reset during bit 3 of 0x81 with 0x55 held
      ifa.tx_valid = 1'b1; ifa.tx_data = 8'h81;
      step();
      ifa.tx_valid = 1'b0;
      step();
      ifa.tx_valid = 1'b1; ifa.tx_data = 8'h55;
      step();
      ifa.tx_valid = 1'b0;
      chk("held_ready", ifa.tx_ready, 0);
      step(); step(); step();
      chk("bit3_out", ifa.out, 0);
      rst = 1'b1;
      #1;
      chk("abort_out", ifa.out, 1);
      chk("abort_ready", ifa.tx_ready, 1);
      chk("abort_busy", ifa.busy, 0);
      chk("abort_done", ifa.done, 0);
      step();
      chk("abort_done2", ifa.done, 0);
      rst = 1'b0;
      send_a(8'h5A);
      // Parity cases (1 then 0 when parity is built in)
      send_a(8'h03);
      send_a(8'h07);
      // Random loopback with gaps
      sent = 0;
      cyc = 0;
      while (sent < 1000 && cyc < 40000) begin
         ifa.tx_valid = ($urandom_range(0, 3) != 0);
         ifa.tx_data  = 8'($urandom);
         rdy = ifa.tx_ready;
         step();
         cyc++;
         if (ifa.tx_valid && rdy) sent++;
      end
      ifa.tx_valid = 1'b0;
      chk("rand_sent", sent, 1000);
      cyc = 0;
      while (ifa.busy && cyc < 40) begin step(); cyc++; end
      chk("drain_busy", ifa.busy, 0);
      step();
      chk("rx_count", rx_cnt, acc_cnt);
      chk("done_count", done_cnt, acc_cnt);
      chk("rx_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
